// File: rtl/i2c_sb_pkg.sv
// Shared types for the I2C transaction scoreboard: error codes, FSM states
// and the layout of a queued expected entry.
package i2c_sb_pkg;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_DATA    = 3'd1;
  localparam logic [2:0] ERR_RW      = 3'd2;
  localparam logic [2:0] ERR_ACK     = 3'd3;
  localparam logic [2:0] ERR_UNEXP   = 3'd4;
  localparam logic [2:0] ERR_MISSING = 3'd5;
  localparam logic [2:0] ERR_PROTO   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Flag bits sit above the data field: entry = {last, nack, rw, data}
  typedef struct packed {
    logic last;
    logic nack;
    logic rw;
  } entry_flags_t;

  function automatic int entry_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/i2c_sb_fifo.sv
// Show-ahead synchronous FIFO holding expected entries; dout is the head
// whenever empty is low. Push when full and pop when empty are ignored.
module i2c_sb_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap for free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_scoreboard_q.sv
// In-order I2C scoreboard: queues expected beats, compares observed beats,
// tracks frame boundaries and keeps saturating pass/error statistics.
module i2c_scoreboard_q
  import i2c_sb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_rw,
  input  logic              exp_nack,
  input  logic              exp_last,
  input  logic              frame_start,
  input  logic              frame_stop,
  input  logic              obs_valid,
  input  logic [DATA_W-1:0] obs_data,
  input  logic              obs_rw,
  input  logic              obs_nack,
  output logic              err_pulse,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [DATA_W-1:0] last_exp,
  output logic [DATA_W-1:0] last_obs,
  output logic              busy
);
  localparam int EW = entry_w(DATA_W);

  state_t              state, state_n;
  logic                frame_done, frame_done_n;
  logic                beat_seen, beat_seen_n;
  logic                push, pop, full, empty;
  logic [EW-1:0]       head;
  logic [$clog2(DEPTH):0] occ;
  entry_flags_t        head_f;
  logic [DATA_W-1:0]   head_data;

  // Up to two errors per cycle: a bad beat plus MISSING on the same stop
  logic [1:0]          n_err;
  logic                n_pass;
  logic [2:0]          code;
  logic                cap;
  logic [CNT_W:0]      err_sum, pass_sum;

  assign exp_ready = !full;
  assign push      = exp_valid && !full;
  assign head_f    = entry_flags_t'(head[EW-1:DATA_W]);
  assign head_data = head[DATA_W-1:0];
  assign busy      = (state != ST_IDLE) || (occ != '0);

  i2c_sb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({exp_last, exp_nack, exp_rw, exp_data}),
    .dout  (head),
    .count (occ),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n      = state;
    frame_done_n = frame_done;
    beat_seen_n  = beat_seen;
    pop          = 1'b0;
    n_err        = 2'd0;
    n_pass       = 1'b0;
    code         = ERR_NONE;
    cap          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (obs_valid) begin
          n_err = 2'd1;
          code  = ERR_PROTO;
        end
        if (frame_start) begin
          state_n      = ST_ACTIVE;
          frame_done_n = 1'b0;
          beat_seen_n  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (obs_valid) begin
          beat_seen_n = 1'b1;
          if (empty) begin
            n_err = 2'd1;
            code  = ERR_UNEXP;
          end else begin
            pop = 1'b1;
            if (head_f.last) frame_done_n = 1'b1;
            if (head_f.rw != obs_rw) begin
              n_err = 2'd1;
              code  = ERR_RW;
            end else if (head_f.nack != obs_nack) begin
              n_err = 2'd1;
              code  = ERR_ACK;
            end else if (!head_f.nack && (head_data != obs_data)) begin
              n_err = 2'd1;
              code  = ERR_DATA;
              cap   = 1'b1;
            end else begin
              n_pass = 1'b1;
            end
          end
        end
        // Stop is judged after this cycle's beat has updated frame_done
        if (frame_stop) begin
          if (frame_done_n || !beat_seen_n) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DRAIN;
            n_err   = n_err + 2'd1;
            code    = ERR_MISSING;
          end
        end
      end
      ST_DRAIN: begin
        if (obs_valid) begin
          n_err = 2'd1;
          code  = ERR_PROTO;
        end
        if (empty) begin
          state_n = ST_IDLE;
        end else begin
          pop = 1'b1;
          if (head_f.last) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign err_sum  = {1'b0, err_cnt}  + {{(CNT_W-1){1'b0}}, n_err};
  assign pass_sum = {1'b0, pass_cnt} + {{CNT_W{1'b0}}, n_pass};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
      beat_seen  <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
      err_cnt    <= '0;
      pass_cnt   <= '0;
      last_exp   <= '0;
      last_obs   <= '0;
    end else begin
      state      <= state_n;
      frame_done <= frame_done_n;
      beat_seen  <= beat_seen_n;
      err_pulse  <= (n_err != 2'd0);
      if (n_err != 2'd0) err_code <= code;
      err_cnt    <= err_sum[CNT_W]  ? '1 : err_sum[CNT_W-1:0];
      pass_cnt   <= pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
      if (cap) begin
        last_exp <= head_data;
        last_obs <= obs_data;
      end
    end
  end

endmodule

// File: tb/tb_i2c_scoreboard_q.sv
// Bench for i2c_scoreboard_q: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_i2c_scoreboard_q;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic exp_valid = 0, exp_rw = 0, exp_nack = 0, exp_last = 0;
  logic [DW-1:0] exp_data = '0, obs_data = '0;
  logic frame_start = 0, frame_stop = 0, obs_valid = 0, obs_rw = 0, obs_nack = 0;
  wire  exp_ready, err_pulse, busy;
  wire  [2:0] err_code;
  wire  [CW-1:0] pass_cnt, err_cnt;
  wire  [DW-1:0] last_exp, last_obs;

  i2c_scoreboard_q #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_data(exp_data), .exp_rw(exp_rw), .exp_nack(exp_nack), .exp_last(exp_last),
    .frame_start(frame_start), .frame_stop(frame_stop), .obs_valid(obs_valid),
    .obs_data(obs_data), .obs_rw(obs_rw), .obs_nack(obs_nack),
    .err_pulse(err_pulse), .err_code(err_code), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .last_exp(last_exp), .last_obs(last_obs), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct { logic [DW-1:0] d; bit rw; bit nack; bit last; } ent_t;
  ent_t q[$];
  int   phase;          // 0 idle, 1 in frame, 2 draining
  bit   done, seen;
  bit   m_pulse;
  int   m_code, m_err, m_pass;
  logic [DW-1:0] m_lexp, m_lobs;
  int   errors = 0, checks = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    q.delete();
    phase = 0; done = 0; seen = 0;
    m_pulse = 0; m_code = 0; m_err = 0; m_pass = 0;
    m_lexp = '0; m_lobs = '0;
  endtask

  task automatic model_step();
    bit   push_ok;
    int   ne, np, code;
    ent_t h, nw;
    push_ok = exp_valid && (q.size() < DEPTH);
    nw = '{exp_data, exp_rw, exp_nack, exp_last};
    ne = 0; np = 0; code = m_code;
    if (phase == 0) begin
      if (obs_valid) begin ne++; code = 6; end
      if (frame_start) begin phase = 1; done = 0; seen = 0; end
    end else if (phase == 1) begin
      if (obs_valid) begin
        seen = 1;
        if (q.size() == 0) begin ne++; code = 4; end
        else begin
          h = q.pop_front();
          if (h.last) done = 1;
          if (h.rw != obs_rw) begin ne++; code = 2; end
          else if (h.nack != obs_nack) begin ne++; code = 3; end
          else if (h.nack) np++;
          else if (h.d != obs_data) begin ne++; code = 1; m_lexp = h.d; m_lobs = obs_data; end
          else np++;
        end
      end
      if (frame_stop) begin
        if (done || !seen) phase = 0;
        else begin phase = 2; ne++; code = 5; end
      end
    end else begin
      if (obs_valid) begin ne++; code = 6; end
      if (q.size() == 0) phase = 0;
      else begin
        h = q.pop_front();
        if (h.last) phase = 0;
      end
    end
    if (push_ok) q.push_back(nw);
    m_pulse = (ne > 0);
    if (ne > 0) m_code = code;
    m_err  = sat(m_err + ne);
    m_pass = sat(m_pass + np);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_all();
    chk("exp_ready", exp_ready, q.size() < DEPTH);
    chk("busy", busy, (phase != 0) || (q.size() != 0));
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_code", err_code, m_code);
    chk("pass_cnt", pass_cnt, m_pass);
    chk("err_cnt", err_cnt, m_err);
    chk("last_exp", last_exp, m_lexp);
    chk("last_obs", last_obs, m_lobs);
  endtask

  // Inputs change at negedge; DUT and model advance on posedge; compare at next negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clr();
    exp_valid = 0; frame_start = 0; frame_stop = 0; obs_valid = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input bit rw, input bit nack, input bit last);
    exp_valid = 1; exp_data = d; exp_rw = rw; exp_nack = nack; exp_last = last;
    tick(); clr();
  endtask

  task automatic obs(input logic [DW-1:0] d, input bit rw, input bit nack);
    obs_valid = 1; obs_data = d; obs_rw = rw; obs_nack = nack;
    tick(); clr();
  endtask

  task automatic start(); frame_start = 1; tick(); clr(); endtask
  task automatic stop();  frame_stop  = 1; tick(); clr(); endtask

  initial begin
    #1 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst exp_ready", exp_ready, 1);
    chk("rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean two-byte write frame
    push(8'hA5, 0, 0, 0);
    push(8'h3C, 0, 0, 1);
    start();
    obs(8'hA5, 0, 0);
    obs(8'h3C, 0, 0);
    stop();
    chk("t1 pass_cnt", pass_cnt, 2);
    chk("t1 err_cnt", err_cnt, 0);
    chk("t1 busy", busy, 0);

    // Data mismatch on a read
    do_reset();
    push(8'h5A, 1, 0, 1);
    start();
    obs(8'h5B, 1, 0);
    chk("t2 err_pulse", err_pulse, 1);
    chk("t2 err_code", err_code, 1);
    chk("t2 last_exp", last_exp, 8'h5A);
    chk("t2 last_obs", last_obs, 8'h5B);
    tick();
    chk("t2 pulse width", err_pulse, 0);
    stop();

    // ACK mismatch, then NACK/NACK with differing data passes
    do_reset();
    push(8'h11, 0, 1, 0);
    push(8'h22, 0, 1, 1);
    start();
    obs(8'h11, 0, 0);
    chk("t3 ack code", err_code, 3);
    obs(8'h99, 0, 1);
    chk("t3 nack pass", pass_cnt, 1);
    chk("t3 err_cnt", err_cnt, 1);
    stop();

    // Short frame -> MISSING and drain of the remainder
    do_reset();
    push(8'h01, 0, 0, 0);
    push(8'h02, 0, 0, 0);
    push(8'h03, 0, 0, 1);
    start();
    obs(8'h01, 0, 0);
    stop();
    chk("t4 missing", err_code, 5);
    chk("t4 pulse", err_pulse, 1);
    tick();
    chk("t4 busy mid", busy, 1);
    tick();
    chk("t4 busy end", busy, 0);
    chk("t4 pass", pass_cnt, 1);

    // PROTO outside a frame, UNEXP on empty queue
    do_reset();
    obs(8'h77, 0, 0);
    chk("t5 proto", err_code, 6);
    start();
    obs(8'h78, 0, 0);
    chk("t5 unexp", err_code, 4);
    chk("t5 err_cnt", err_cnt, 2);
    stop();
    tick();

    // Full queue, push+pop while full, then reset mid-frame
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(i), 0, 0, i == DEPTH - 1);
    chk("t6 full", exp_ready, 0);
    start();
    exp_valid = 1; exp_data = 8'hEE; exp_rw = 0; exp_nack = 0; exp_last = 0;
    obs_valid = 1; obs_data = 8'h00; obs_rw = 0; obs_nack = 0;
    tick(); clr();
    chk("t6 ready after pop", exp_ready, 1);
    chk("t6 pass", pass_cnt, 1);
    obs(8'h01, 0, 0);
    obs(8'hFF, 0, 0);
    do_reset();
    chk("t6 rst busy", busy, 0);
    chk("t6 rst err_cnt", err_cnt, 0);
    chk("t6 rst last_exp", last_exp, 0);

    // Random traffic, mostly well-formed beats with occasional corruption
    for (int c = 0; c < 4000; c++) begin
      int r;
      clr();
      if ($urandom_range(999) == 0) begin
        do_reset();
        clr();
      end
      exp_valid = ($urandom_range(2) == 0);
      exp_data  = 8'($urandom_range(3));
      exp_rw    = ($urandom_range(3) == 0);
      exp_nack  = ($urandom_range(3) == 0);
      exp_last  = ($urandom_range(2) == 0);
      frame_start = ($urandom_range(14) == 0);
      frame_stop  = ($urandom_range(11) == 0);
      obs_valid   = ($urandom_range(2) == 0);
      if (q.size() > 0 && $urandom_range(3) != 0) begin
        obs_data = q[0].d; obs_rw = q[0].rw; obs_nack = q[0].nack;
        r = $urandom_range(9);
        if (r == 0) obs_data = obs_data ^ 8'h01;
        if (r == 1) obs_rw = ~obs_rw;
        if (r == 2) obs_nack = ~obs_nack;
      end else begin
        obs_data = 8'($urandom_range(3));
        obs_rw   = ($urandom_range(1) == 0);
        obs_nack = ($urandom_range(3) == 0);
      end
      tick();
    end
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
